// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID->EX pipeline register.
// Stall bit indices, ALU load opcodes, NOP codes, enable/delay-slot flags.
package id_ex_reg_pkg;

  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;

  localparam logic WRITE_ENABLE   = 1'b1;
  localparam logic WRITE_DISABLE  = 1'b0;
  localparam logic IN_DELAY_SLOT  = 1'b1;
  localparam logic NOT_IN_DELAY_SLOT = 1'b0;

  localparam logic [7:0] ALU_OP_NOP = 8'b0000_0000;
  localparam logic [2:0] ALU_RES_NOP = 3'b000;

  localparam logic [7:0] ALU_OP_LB  = 8'b1110_0000;
  localparam logic [7:0] ALU_OP_LBU = 8'b1110_0100;
  localparam logic [7:0] ALU_OP_LH  = 8'b1110_0001;
  localparam logic [7:0] ALU_OP_LHU = 8'b1110_0101;
  localparam logic [7:0] ALU_OP_LW  = 8'b1110_0011;
  localparam logic [7:0] ALU_OP_LWL = 8'b1110_0010;
  localparam logic [7:0] ALU_OP_LWR = 8'b1110_0110;
  localparam logic [7:0] ALU_OP_LL  = 8'b1111_0000;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {ALU_OP_LB, ALU_OP_LBU, ALU_OP_LH,
                      ALU_OP_LHU, ALU_OP_LW, ALU_OP_LWL,
                      ALU_OP_LWR, ALU_OP_LL};
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID->EX bundle: decoded fields from id and their registered ex copies.
// master = id/ex side driving id_*, slave = the pipeline register.
interface id_ex_reg_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int SELW = 3
);
  logic [OPW-1:0]  id_aluop;
  logic [SELW-1:0] id_alusel;
  logic [DW-1:0]   id_reg1;
  logic [DW-1:0]   id_reg2;
  logic [AW-1:0]   id_wd;
  logic            id_wreg;
  logic [DW-1:0]   id_return_addr;
  logic [DW-1:0]   id_inst;
  logic [DW-1:0]   id_pc;
  logic            id_is_in_delayslot;
  logic            next_inst_in_delayslot_i;
  logic            id_reg1_read;
  logic [AW-1:0]   id_reg1_addr;
  logic            id_reg2_read;
  logic [AW-1:0]   id_reg2_addr;

  logic [OPW-1:0]  ex_aluop;
  logic [SELW-1:0] ex_alusel;
  logic [DW-1:0]   ex_reg1;
  logic [DW-1:0]   ex_reg2;
  logic [AW-1:0]   ex_wd;
  logic            ex_wreg;
  logic [DW-1:0]   ex_return_addr;
  logic [DW-1:0]   ex_inst;
  logic [DW-1:0]   ex_pc;
  logic            ex_is_in_delayslot;

  modport master (
    output id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
           id_return_addr, id_inst, id_pc, id_is_in_delayslot,
           next_inst_in_delayslot_i, id_reg1_read, id_reg1_addr,
           id_reg2_read, id_reg2_addr,
    input  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
           ex_return_addr, ex_inst, ex_pc, ex_is_in_delayslot
  );

  modport slave (
    input  id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
           id_return_addr, id_inst, id_pc, id_is_in_delayslot,
           next_inst_in_delayslot_i, id_reg1_read, id_reg1_addr,
           id_reg2_read, id_reg2_addr,
    output ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
           ex_return_addr, ex_inst, ex_pc, ex_is_in_delayslot
  );
endinterface

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard check: a load in EX whose destination is read by ID.
// Purely combinational; $0 never forms a hazard.
module load_use_detect #(
  parameter int AW = 5
) (
  input  logic          load_flag,
  input  logic          ex_wreg,
  input  logic [AW-1:0] ex_wd,
  input  logic          reg1_read,
  input  logic [AW-1:0] reg1_addr,
  input  logic          reg2_read,
  input  logic [AW-1:0] reg2_addr,
  output logic          stallreq
);
  logic hit1;
  logic hit2;

  assign hit1 = reg1_read && (reg1_addr == ex_wd);
  assign hit2 = reg2_read && (reg2_addr == ex_wd);

  assign stallreq = load_flag && ex_wreg &&
                    (ex_wd != '0) && (hit1 || hit2);
endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with delay-slot tracking and load-use stall request.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
import id_ex_reg_pkg::*;

module id_ex_reg #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8,
  parameter int SELW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  id_ex_reg_if.slave  bus,
  output logic        is_in_delayslot_o,
  output logic        stallreq_o,
  output logic [31:0] bubble_cnt_o
);
  logic [OPW-1:0]  aluop_q;
  logic [SELW-1:0] alusel_q;
  logic [DW-1:0]   reg1_q;
  logic [DW-1:0]   reg2_q;
  logic [AW-1:0]   wd_q;
  logic            wreg_q;
  logic [DW-1:0]   ra_q;
  logic [DW-1:0]   inst_q;
  logic [DW-1:0]   pc_q;
  logic            ds_q;
  logic            next_ds_q;
  logic            load_q;

  logic bubble;
  logic capture;
  logic unused_stall;

  // flush dominates; an ID-only stall inserts a bubble, a full stall holds
  assign bubble  = flush || (stall[STALL_ID] && !stall[STALL_EX]);
  assign capture = !stall[STALL_ID];
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluop_q   <= OPW'(ALU_OP_NOP);
      alusel_q  <= SELW'(ALU_RES_NOP);
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= WRITE_DISABLE;
      ra_q      <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      ds_q      <= NOT_IN_DELAY_SLOT;
      next_ds_q <= NOT_IN_DELAY_SLOT;
      load_q    <= 1'b0;
    end else if (bubble) begin
      aluop_q   <= OPW'(ALU_OP_NOP);
      alusel_q  <= SELW'(ALU_RES_NOP);
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= WRITE_DISABLE;
      ra_q      <= '0;
      inst_q    <= '0;
      pc_q      <= '0;
      ds_q      <= NOT_IN_DELAY_SLOT;
      load_q    <= 1'b0;
      if (flush)
        next_ds_q <= NOT_IN_DELAY_SLOT;
    end else if (capture) begin
      aluop_q   <= bus.id_aluop;
      alusel_q  <= bus.id_alusel;
      reg1_q    <= bus.id_reg1;
      reg2_q    <= bus.id_reg2;
      wd_q      <= bus.id_wd;
      wreg_q    <= bus.id_wreg;
      ra_q      <= bus.id_return_addr;
      inst_q    <= bus.id_inst;
      pc_q      <= bus.id_pc;
      ds_q      <= bus.id_is_in_delayslot;
      next_ds_q <= bus.next_inst_in_delayslot_i;
      load_q    <= is_load_op(8'(bus.id_aluop));
    end
  end

  assign bus.ex_aluop           = aluop_q;
  assign bus.ex_alusel          = alusel_q;
  assign bus.ex_reg1            = reg1_q;
  assign bus.ex_reg2            = reg2_q;
  assign bus.ex_wd              = wd_q;
  assign bus.ex_wreg            = wreg_q;
  assign bus.ex_return_addr     = ra_q;
  assign bus.ex_inst            = inst_q;
  assign bus.ex_pc              = pc_q;
  assign bus.ex_is_in_delayslot = ds_q;
  assign is_in_delayslot_o      = next_ds_q;

  load_use_detect #(.AW(AW)) u_lud (
    .load_flag (load_q),
    .ex_wreg   (wreg_q),
    .ex_wd     (wd_q),
    .reg1_read (bus.id_reg1_read),
    .reg1_addr (bus.id_reg1_addr),
    .reg2_read (bus.id_reg2_read),
    .reg2_addr (bus.id_reg2_addr),
    .stallreq  (stallreq_o)
  );

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (bubble)
      cnt_q <= cnt_q + 32'd1;
  end

  assign bubble_cnt_o = cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: reference model of the ID->EX rules plus directed
// vectors with literal expectations.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        is_in_delayslot_o;
  logic        stallreq_o;
  logic [31:0] bubble_cnt_o;
  logic        run = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .bus               (bus),
    .is_in_delayslot_o (is_in_delayslot_o),
    .stallreq_o        (stallreq_o),
    .bubble_cnt_o      (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_LW   = 8'hE3;
  localparam logic [7:0] OP_LB   = 8'hE0;
  localparam logic [7:0] OP_BEQ  = 8'h51;
  localparam logic [7:0] LOADS [8] =
    '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE2, 8'hE6, 8'hF0};

  // model: what EX currently holds, as a plain record
  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2, ra, inst, pc;
    logic [4:0]  wd;
    logic        wreg, ds, next_ds;
  } ex_rec_t;

  ex_rec_t m = '{default: '0};
  int unsigned m_bubbles = 0;

  function automatic logic op_loads(input logic [7:0] op);
    foreach (LOADS[i]) if (LOADS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_stallreq();
    logic dep;
    dep = (bus.id_reg1_read && bus.id_reg1_addr == m.wd) ||
          (bus.id_reg2_read && bus.id_reg2_addr == m.wd);
    return !rst && op_loads(m.aluop) && m.wreg && m.wd != 0 && dep;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '{default: '0};
      m_bubbles = 0;
    end else if (flush) begin
      m = '{default: '0};
      m_bubbles++;
    end else if (stall[2] && !stall[3]) begin
      m = '{aluop: 8'h0, alusel: 3'h0, reg1: 0, reg2: 0, ra: 0,
            inst: 0, pc: 0, wd: 0, wreg: 0, ds: 0, next_ds: m.next_ds};
      m_bubbles++;
    end else if (!stall[2]) begin
      m.aluop   = bus.id_aluop;
      m.alusel  = bus.id_alusel;
      m.reg1    = bus.id_reg1;
      m.reg2    = bus.id_reg2;
      m.wd      = bus.id_wd;
      m.wreg    = bus.id_wreg;
      m.ra      = bus.id_return_addr;
      m.inst    = bus.id_inst;
      m.pc      = bus.id_pc;
      m.ds      = bus.id_is_in_delayslot;
      m.next_ds = bus.next_inst_in_delayslot_i;
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("aluop",  64'(bus.ex_aluop),  64'(m.aluop));
      chk("alusel", 64'(bus.ex_alusel), 64'(m.alusel));
      chk("reg1",   64'(bus.ex_reg1),   64'(m.reg1));
      chk("reg2",   64'(bus.ex_reg2),   64'(m.reg2));
      chk("wd",     64'(bus.ex_wd),     64'(m.wd));
      chk("wreg",   64'(bus.ex_wreg),   64'(m.wreg));
      chk("ret",    64'(bus.ex_return_addr), 64'(m.ra));
      chk("inst",   64'(bus.ex_inst),   64'(m.inst));
      chk("pc",     64'(bus.ex_pc),     64'(m.pc));
      chk("ex_ds",  64'(bus.ex_is_in_delayslot), 64'(m.ds));
      chk("ds_o",   64'(is_in_delayslot_o), 64'(m.next_ds));
      chk("stallreq", 64'(stallreq_o), 64'(exp_stallreq()));
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("bubbles", 64'(bubble_cnt_o), 64'(m_bubbles));
`else
      chk("bubbles", 64'(bubble_cnt_o), 64'd0);
`endif
    end
  end

  logic [31:0] pc_next = 32'h0000_1000;

  task automatic set_id(input logic [7:0] op, input logic [2:0] sel,
                        input logic [4:0] wd, input logic wreg,
                        input logic [31:0] r1, input logic [31:0] r2);
    bus.id_aluop  = op;
    bus.id_alusel = sel;
    bus.id_wd     = wd;
    bus.id_wreg   = wreg;
    bus.id_reg1   = r1;
    bus.id_reg2   = r2;
    bus.id_inst   = {op, 19'h0, wd};
    bus.id_pc     = pc_next;
    bus.id_return_addr = pc_next + 32'd8;
    bus.id_is_in_delayslot = 1'b0;
    bus.next_inst_in_delayslot_i = 1'b0;
    bus.id_reg1_read = 1'b0;
    bus.id_reg1_addr = '0;
    bus.id_reg2_read = 1'b0;
    bus.id_reg2_addr = '0;
    pc_next = pc_next + 32'd4;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_aluop", 64'(bus.ex_aluop), 64'd0);
    chk("rst_wd",    64'(bus.ex_wd),    64'd0);
    chk("rst_reg2",  64'(bus.ex_reg2),  64'd0);
    chk("rst_ds_o",  64'(is_in_delayslot_o), 64'd0);
    chk("rst_stallreq", 64'(stallreq_o), 64'd0);
    chk("rst_bubbles", 64'(bubble_cnt_o), 64'd0);
    edge1();
    rst = 1'b0;
  endtask

  initial begin
    set_id(8'h0, 3'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;

    // 1: ORI captured, then reset lands while ID keeps presenting it
    set_id(OP_OR, 3'b001, 5'd3, 1'b1, 32'h10, 32'h55);
    edge1();
    chk("ori_aluop", 64'(bus.ex_aluop), 64'h25);
    pulse_reset();

    // 2: ADDU capture, then a full stall holds it
    set_id(OP_ADDU, 3'b100, 5'd5, 1'b1, 32'd7, 32'd9);
    edge1();
    chk("addu_wd",   64'(bus.ex_wd),   64'd5);
    chk("addu_wreg", 64'(bus.ex_wreg), 64'd1);
    stall = 6'b001111;
    set_id(OP_OR, 3'b001, 5'd6, 1'b1, 32'd1, 32'd2);
    edge1();
    chk("hold_wd",   64'(bus.ex_wd),   64'd5);
    chk("hold_reg1", 64'(bus.ex_reg1), 64'd7);
    stall = 6'b000000;

    // 3: LW $8 followed by a dependent read of $8
    set_id(OP_LW, 3'b111, 5'd8, 1'b1, 32'h100, 32'h0);
    edge1();
    set_id(OP_ADDU, 3'b100, 5'd9, 1'b1, 32'd3, 32'd4);
    bus.id_reg1_read = 1'b1;
    bus.id_reg1_addr = 5'd8;
    #1 chk("lu_stallreq", 64'(stallreq_o), 64'd1);
    stall = 6'b000111;
    edge1();
    chk("lu_bubble_wreg", 64'(bus.ex_wreg), 64'd0);
    chk("lu_drop", 64'(stallreq_o), 64'd0);
    stall = 6'b000000;
    edge1();
    chk("lu_dep_wd", 64'(bus.ex_wd), 64'd9);

    // 4: $0 destination and unused read port never stall
    set_id(OP_LW, 3'b111, 5'd0, 1'b1, 32'h0, 32'h0);
    edge1();
    set_id(OP_ADDU, 3'b100, 5'd2, 1'b1, 32'd0, 32'd0);
    bus.id_reg1_read = 1'b1;
    bus.id_reg1_addr = 5'd0;
    #1 chk("zero_stallreq", 64'(stallreq_o), 64'd0);
    set_id(OP_LB, 3'b111, 5'd8, 1'b1, 32'h0, 32'h0);
    edge1();
    set_id(OP_ADDU, 3'b100, 5'd2, 1'b1, 32'd0, 32'd0);
    bus.id_reg1_read = 1'b1;
    bus.id_reg1_addr = 5'd3;
    bus.id_reg2_addr = 5'd8;
    #1 chk("noread_stallreq", 64'(stallreq_o), 64'd0);
    bus.id_reg2_read = 1'b1;
    #1 chk("read2_stallreq", 64'(stallreq_o), 64'd1);

    // 5: taken branch marks the next slot; flush clears it
    set_id(OP_BEQ, 3'b110, 5'd0, 1'b0, 32'd1, 32'd1);
    bus.next_inst_in_delayslot_i = 1'b1;
    edge1();
    chk("br_ds_o", 64'(is_in_delayslot_o), 64'd1);
    set_id(OP_ADDU, 3'b100, 5'd4, 1'b1, 32'd5, 32'd6);
    bus.id_is_in_delayslot = 1'b1;
    flush = 1'b1;
    edge1();
    chk("fl_ds_o",  64'(is_in_delayslot_o), 64'd0);
    chk("fl_wreg",  64'(bus.ex_wreg),  64'd0);
    chk("fl_aluop", 64'(bus.ex_aluop), 64'd0);
    flush = 1'b0;

    // mid-stall reset must not leave a stale delay-slot flag
    set_id(OP_BEQ, 3'b110, 5'd0, 1'b0, 32'd2, 32'd2);
    bus.next_inst_in_delayslot_i = 1'b1;
    edge1();
    stall = 6'b001111;
    pulse_reset();

    // 6: three flushes (one over a full stall) and two ID bubbles
    stall = 6'b000000;
    set_id(OP_ADDU, 3'b100, 5'd7, 1'b1, 32'd1, 32'd1);
    edge1();
    flush = 1'b1;
    edge1();
    stall = 6'b001111;
    edge1();
    chk("fl_over_stall_wd", 64'(bus.ex_wd), 64'd0);
    stall = 6'b000000;
    edge1();
    flush = 1'b0;
    stall = 6'b000111;
    repeat (2) edge1();
    stall = 6'b000000;
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubble_cnt", 64'(bubble_cnt_o), 64'd5);
`else
    chk("bubble_cnt", 64'(bubble_cnt_o), 64'd0);
`endif
    edge1();
    chk("after_wd", 64'(bus.ex_wd), 64'd7);
    edge1();

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
